// File: rtl/gf2m_inv_seq_if.sv
// gf2m_inv_seq_if: request/result bundle for the GF(2^M) inverter.
//   i_start, i_x (i_num with GF_INV_DIVIDE_EN) : requester -> inverter
//   o_busy, o_valid, o_y, o_zero                : inverter -> requester
//   master = requester side, slave = inverter side.
interface gf2m_inv_seq_if #(parameter int M = 8);
    logic         i_start;
    logic [M-1:0] i_x;
`ifdef GF_INV_DIVIDE_EN
    logic [M-1:0] i_num;
`endif
    logic         o_busy;
    logic         o_valid;
    logic [M-1:0] o_y;
    logic         o_zero;
`ifdef GF_INV_DIVIDE_EN
    modport master (output i_start, i_x, i_num, input o_busy, o_valid, o_y, o_zero);
    modport slave  (input i_start, i_x, i_num, output o_busy, o_valid, o_y, o_zero);
`else
    modport master (output i_start, i_x, input o_busy, o_valid, o_y, o_zero);
    modport slave  (input i_start, i_x, output o_busy, o_valid, o_y, o_zero);
`endif
endinterface

// File: rtl/gf2m_inv_seq.sv
// gf2m_inv_seq: iterative GF(2^M) inverter, y = x^(2^M-2), square-and-multiply.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_start/i_x[/i_num] in, o_busy/o_valid/o_y/o_zero out
//   Optional macro GF_INV_DIVIDE_EN adds i_num and a DIV state giving y = num/x.
module gf2m_inv_seq #(
    parameter int M    = 8,
    parameter int POLY = 285
) (
    input  logic          i_clk,
    input  logic          i_rst,
    gf2m_inv_seq_if.slave bus
);
    localparam int CW = $clog2(M);
    localparam logic [M-1:0] RED = M'(POLY);
    if (M < 2 || M > 16 || ((POLY >> M) & 1) == 0) begin : g_param_chk
        $error("gf2m_inv_seq: M must be 2..16 and POLY bit M must be set");
    end
`ifdef GF_INV_DIVIDE_EN
    typedef enum logic [1:0] {IDLE, RUN, DIV} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p, s;
        p = '0;
        s = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p ^= s;
            s = {s[M-2:0], 1'b0} ^ (s[M-1] ? RED : '0);
        end
        return p;
    endfunction
    state_t        state_q, state_d;
    logic [M-1:0]  sq_q, sq_d, acc_q, acc_d, y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d, valid_q, valid_d;
    logic [M-1:0]  mul_a, mul_b, sq_in;
    // mul_a: accumulator product (acc*sq in RUN, acc*num in DIV); mul_b: squarer
    // fed by the operand in IDLE so the first square is ready on the accepting edge.
    assign sq_in = (state_q == IDLE) ? bus.i_x : sq_q;
    assign mul_b = gf_mul(sq_in, sq_in);
`ifdef GF_INV_DIVIDE_EN
    logic [M-1:0] num_q, num_d;
    assign mul_a = gf_mul(acc_q, (state_q == DIV) ? num_q : sq_q);
`else
    assign mul_a = gf_mul(acc_q, sq_q);
`endif
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
`ifdef GF_INV_DIVIDE_EN
        num_d   = num_q;
`endif
        case (state_q)
            IDLE: if (bus.i_start) begin
                sq_d    = mul_b;
                acc_d   = M'(1);
                cnt_d   = CW'(1);
                zero_d  = (bus.i_x == '0);
`ifdef GF_INV_DIVIDE_EN
                num_d   = bus.i_num;
`endif
                state_d = RUN;
            end
            RUN: begin
                acc_d = mul_a;
                sq_d  = mul_b;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) begin
`ifdef GF_INV_DIVIDE_EN
                    state_d = DIV;
`else
                    y_d     = mul_a;
                    valid_d = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef GF_INV_DIVIDE_EN
            DIV: begin
                y_d     = mul_a;
                valid_d = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef GF_INV_DIVIDE_EN
            num_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
`ifdef GF_INV_DIVIDE_EN
            num_q   <= num_d;
`endif
        end
    end
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_y     = y_q;
    assign bus.o_zero  = zero_q;
endmodule

// File: tb/tb_gf2m_inv_seq.sv
// tb_gf2m_inv_seq: directed bench for gf2m_inv_seq at M=8, M=4 and M=16.
module tb_gf2m_inv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
`ifdef GF_INV_DIVIDE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT8  = 7 + EXTRA;
    localparam int LAT4  = 3 + EXTRA;
    localparam int LAT16 = 15 + EXTRA;
    always #5 clk = ~clk;
    gf2m_inv_seq_if #(.M(8))  if8 ();
    gf2m_inv_seq_if #(.M(4))  if4 ();
    gf2m_inv_seq_if #(.M(16)) if16 ();
    gf2m_inv_seq #(.M(8),  .POLY(285))     dut8  (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
    gf2m_inv_seq #(.M(4),  .POLY(19))      dut4  (.i_clk(clk), .i_rst(rst), .bus(if4.slave));
    gf2m_inv_seq #(.M(16), .POLY(69643))   dut16 (.i_clk(clk), .i_rst(rst), .bus(if16.slave));
    function automatic int gmul(int a, int b, int m, int poly);
        int r;
        int s;
        r = 0;
        s = a;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) != 0) r ^= s;
            s = s << 1;
            if (((s >> m) & 1) != 0) s ^= poly;
        end
        return r;
    endfunction
    task automatic issue8(input logic [7:0] x);
        if8.i_start = 1'b1;
        if8.i_x = x;
        @(negedge clk);
        if8.i_start = 1'b0;
    endtask
    task automatic wait8(output int lat);
        lat = 0;
        while (!if8.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic test_reset;
        if8.i_start = 1'b1;
        if8.i_x = 8'h02;
        repeat (3) @(negedge clk);
        checks++;
        if (if8.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if8.o_busy); end
        checks++;
        if (if8.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if8.o_valid); end
        checks++;
        if (if8.o_y !== 8'h00) begin errors++; $display("FAIL reset_y got %h want 00", if8.o_y); end
        checks++;
        if (if8.o_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", if8.o_zero); end
        if8.i_start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_basic;
        int lat;
        int nbusy;
        issue8(8'h02);
        lat = 0;
        nbusy = 0;
        while (!if8.o_valid && lat < 40) begin
            if (if8.o_busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT8) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT8); end
        checks++;
        if (nbusy != LAT8) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", nbusy, LAT8); end
        checks++;
        if (if8.o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid got %b want 0", if8.o_busy); end
        checks++;
        if (if8.o_y !== 8'h8E) begin errors++; $display("FAIL basic_y got %h want 8e", if8.o_y); end
        checks++;
        if (if8.o_zero !== 1'b0) begin errors++; $display("FAIL basic_zero got %b want 0", if8.o_zero); end
        @(negedge clk);
        checks++;
        if (if8.o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", if8.o_valid); end
        checks++;
        if (if8.o_y !== 8'h8E) begin errors++; $display("FAIL basic_y_hold got %h want 8e", if8.o_y); end
    endtask
    task automatic test_one_zero;
        int lat;
        issue8(8'h01);
        wait8(lat);
        checks++;
        if (lat != LAT8 || if8.o_y !== 8'h01) begin errors++; $display("FAIL one_y got %h lat %0d want 01 lat %0d", if8.o_y, lat, LAT8); end
        @(negedge clk);
        issue8(8'h00);
        wait8(lat);
        checks++;
        if (lat != LAT8 || if8.o_y !== 8'h00) begin errors++; $display("FAIL zero_y got %h lat %0d want 00 lat %0d", if8.o_y, lat, LAT8); end
        checks++;
        if (if8.o_zero !== 1'b1) begin errors++; $display("FAIL zero_flag got %b want 1", if8.o_zero); end
        @(negedge clk);
    endtask
    task automatic test_ignore;
        int pulses;
        logic [7:0] yv;
        issue8(8'h02);
        repeat (2) @(negedge clk);
        if8.i_start = 1'b1;
        if8.i_x = 8'h03;
        @(negedge clk);
        if8.i_start = 1'b0;
        pulses = 0;
        yv = 8'hFF;
        for (int c = 0; c < LAT8 + 4; c++) begin
            if (if8.o_valid) begin
                pulses++;
                yv = if8.o_y;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        checks++;
        if (yv !== 8'h8E) begin errors++; $display("FAIL ignore_y got %h want 8e", yv); end
    endtask
    task automatic test_reset_mid;
        int pulses;
        int lat;
        issue8(8'h05);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (if8.o_busy !== 1'b0 || if8.o_valid !== 1'b0 || if8.o_y !== 8'h00 || if8.o_zero !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got busy %b valid %b y %h zero %b want all 0", if8.o_busy, if8.o_valid, if8.o_y, if8.o_zero);
        end
        pulses = 0;
        for (int c = 0; c < LAT8 + 2; c++) begin
            if (if8.o_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midreset_no_valid got %0d want 0", pulses); end
        issue8(8'h02);
        wait8(lat);
        checks++;
        if (lat != LAT8 || if8.o_y !== 8'h8E) begin errors++; $display("FAIL midreset_restart got %h lat %0d want 8e lat %0d", if8.o_y, lat, LAT8); end
        @(negedge clk);
    endtask
    task automatic test_back_to_back;
        int lat;
        issue8(8'h01);
        for (int x = 1; x < 256; x++) begin
            wait8(lat);
            checks++;
            if (lat != LAT8 || gmul(x, int'(if8.o_y), 8, 285) != 1) begin
                errors++;
                $display("FAIL sweep_x%02h got y %h lat %0d want inverse lat %0d", x, if8.o_y, lat, LAT8);
            end
            if (x < 255) issue8(8'(x + 1));
        end
        @(negedge clk);
    endtask
    task automatic test_m4;
        int lat;
        if4.i_start = 1'b1;
        if4.i_x = 4'h2;
        @(negedge clk);
        if4.i_start = 1'b0;
        lat = 0;
        while (!if4.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT4 || if4.o_y !== 4'h9) begin errors++; $display("FAIL m4_y got %h lat %0d want 9 lat %0d", if4.o_y, lat, LAT4); end
        @(negedge clk);
    endtask
    task automatic test_m16;
        int lat;
        int x;
        for (int k = 0; k < 20; k++) begin
            x = (k == 0) ? 1 : (k == 1) ? 65535 : int'($urandom_range(1, 65535));
            if16.i_start = 1'b1;
            if16.i_x = 16'(x);
            @(negedge clk);
            if16.i_start = 1'b0;
            lat = 0;
            while (!if16.o_valid && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != LAT16 || gmul(x, int'(if16.o_y), 16, 69643) != 1) begin
                errors++;
                $display("FAIL m16_x%04h got y %h lat %0d want inverse lat %0d", x, if16.o_y, lat, LAT16);
            end
            @(negedge clk);
        end
    endtask
`ifdef GF_INV_DIVIDE_EN
    task automatic test_divide;
        int lat;
        if8.i_num = 8'h03;
        issue8(8'h02);
        wait8(lat);
        checks++;
        if (lat != 8 || if8.o_y !== 8'h8F) begin errors++; $display("FAIL div_y got %h lat %0d want 8f lat 8", if8.o_y, lat); end
        @(negedge clk);
        issue8(8'h00);
        wait8(lat);
        checks++;
        if (if8.o_y !== 8'h00 || if8.o_zero !== 1'b1) begin errors++; $display("FAIL div_zero got y %h zero %b want 00 1", if8.o_y, if8.o_zero); end
        if8.i_num = 8'h01;
        @(negedge clk);
    endtask
`endif
    initial begin
        if8.i_start = 1'b0;
        if8.i_x = '0;
        if4.i_start = 1'b0;
        if4.i_x = '0;
        if16.i_start = 1'b0;
        if16.i_x = '0;
`ifdef GF_INV_DIVIDE_EN
        if8.i_num = 8'h01;
        if4.i_num = 4'h1;
        if16.i_num = 16'h0001;
`endif
        @(negedge clk);
        test_reset;
        test_basic;
        test_one_zero;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        test_m4;
        test_m16;
`ifdef GF_INV_DIVIDE_EN
        test_divide;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
